passcode_checker: RTL and testbench

PASSCODE_CHECKER -- requirements
Module: passcode_checker

---
 rtl/passcode_checker.sv | 206 ++++++++++++++++++++
 tb/tb_passcode_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_checker.sv
// rtl/passcode_checker.sv - keypad passcode checker with change mode and lockout
//
// Purpose: collects keypad digits, checks them against a stored passcode on the
// star key, supports changing the passcode (enter new code, confirm it) while
// open, restores the default all-zero code on clear_code, and locks the keypad
// for LOCK_CYCLES cycles after MAX_FAIL consecutive wrong entries.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   on                    safe powered (level); low clears entry and closes
//   digit_valid, digit    one-cycle digit strobe and its key code
//   enter                 one-cycle star-key strobe
//   change_req            one-cycle request to change the passcode
//   clear_code            one-cycle request to restore the default passcode
//   unlock, fail, changed one-cycle result pulses, one cycle after the strobe
//   open, locked, changing status levels
//   len_leds              thermometer of the entry count (bit i = count > i)
module passcode_checker #(
  parameter int MAX_LEN     = 6,
  parameter int MIN_LEN     = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               on,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  input  logic               change_req,
  input  logic               clear_code,
  output logic               unlock,
  output logic               fail,
  output logic               changed,
  output logic               open,
  output logic               locked,
  output logic               changing,
  output logic [MAX_LEN-1:0] len_leds
);

  localparam int CNT_W  = $clog2(MAX_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  // The timer counts LOCK_CYCLES-1 down to 0, so it never needs LOCK_CYCLES itself.
  localparam int TMR_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef logic [MAX_LEN-1:0][DIGIT_W-1:0] code_t;
  typedef enum logic [1:0] {ENTRY, CHG_NEW, CHG_CONFIRM, LOCKOUT} state_t;

  state_t             state_q, state_d;
  code_t              entry_q, entry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  code_t              code_q, code_d;
  logic [CNT_W-1:0]   code_len_q, code_len_d;
  code_t              temp_q, temp_d;
  logic [CNT_W-1:0]   temp_len_q, temp_len_d;
  logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               open_d, unlock_d, fail_d, changed_d;
  logic [MAX_LEN-1:0] len_leds_d;
  logic               entry_match, temp_match;
  logic [FAIL_W-1:0]  fail_cnt_inc;

  // Only the first count_q digits of the buffer are meaningful.
  always_comb begin
    entry_match = (count_q == code_len_q);
    temp_match  = (count_q == temp_len_q);
    for (int i = 0; i < MAX_LEN; i++) begin
      if (CNT_W'(i) < count_q) begin
        if (entry_q[i] != code_q[i]) entry_match = 1'b0;
        if (entry_q[i] != temp_q[i]) temp_match  = 1'b0;
      end
    end
  end

  assign fail_cnt_inc = fail_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    count_d    = count_q;
    code_d     = code_q;
    code_len_d = code_len_q;
    temp_d     = temp_q;
    temp_len_d = temp_len_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    open_d     = open;
    unlock_d   = 1'b0;
    fail_d     = 1'b0;
    changed_d  = 1'b0;

    // Lockout runs to completion regardless of power or key events.
    if (state_q == LOCKOUT) begin
      if (timer_q == '0) begin
        state_d    = ENTRY;
        fail_cnt_d = '0;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end else if (!on) begin
      count_d = '0;
      open_d  = 1'b0;
      state_d = ENTRY;
    end else if (clear_code) begin
      code_d     = '0;
      code_len_d = CNT_W'(MAX_LEN);
      count_d    = '0;
      state_d    = ENTRY;
    end else if (enter) begin
      count_d = '0;
      case (state_q)
        ENTRY: begin
          if (entry_match) begin
            unlock_d   = 1'b1;
            open_d     = 1'b1;
            fail_cnt_d = '0;
          end else begin
            fail_d     = 1'b1;
            fail_cnt_d = fail_cnt_inc;
            if (fail_cnt_inc == FAIL_W'(MAX_FAIL)) begin
              state_d = LOCKOUT;
              timer_d = TMR_W'(LOCK_CYCLES - 1);
            end
          end
        end
        CHG_NEW: begin
          if (count_q >= CNT_W'(MIN_LEN)) begin
            temp_d     = entry_q;
            temp_len_d = count_q;
            state_d    = CHG_CONFIRM;
          end else begin
            fail_d = 1'b1;
          end
        end
        CHG_CONFIRM: begin
          if (temp_match) begin
            code_d     = temp_q;
            code_len_d = temp_len_q;
            changed_d  = 1'b1;
            state_d    = ENTRY;
          end else begin
            fail_d  = 1'b1;
            state_d = CHG_NEW;
          end
        end
        default: ;
      endcase
    end else if (change_req) begin
      if (state_q == ENTRY && open) begin
        count_d = '0;
        state_d = CHG_NEW;
      end
    end else if (digit_valid) begin
      if (count_q < CNT_W'(MAX_LEN)) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (CNT_W'(i) == count_q) entry_d[i] = digit;
        end
        count_d = count_q + 1'b1;
      end
    end

    for (int i = 0; i < MAX_LEN; i++) begin
      len_leds_d[i] = (count_d > CNT_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ENTRY;
      entry_q    <= '0;
      count_q    <= '0;
      code_q     <= '0;
      code_len_q <= CNT_W'(MAX_LEN);
      temp_q     <= '0;
      temp_len_q <= '0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      unlock     <= 1'b0;
      fail       <= 1'b0;
      changed    <= 1'b0;
      open       <= 1'b0;
      locked     <= 1'b0;
      changing   <= 1'b0;
      len_leds   <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      count_q    <= count_d;
      code_q     <= code_d;
      code_len_q <= code_len_d;
      temp_q     <= temp_d;
      temp_len_q <= temp_len_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      unlock     <= unlock_d;
      fail       <= fail_d;
      changed    <= changed_d;
      open       <= open_d;
      locked     <= (state_d == LOCKOUT);
      changing   <= (state_d == CHG_NEW) || (state_d == CHG_CONFIRM);
      len_leds   <= len_leds_d;
    end
  end

endmodule

// File: tb/tb_passcode_checker.sv
// tb/tb_passcode_checker.sv - self-checking bench for passcode_checker
module tb_passcode_checker;

  localparam int MAX_LEN     = 6;
  localparam int MIN_LEN     = 4;
  localparam int DIGIT_W     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 1000;

  logic clk = 1'b0;
  logic reset, on, digit_valid, enter, change_req, clear_code;
  logic [DIGIT_W-1:0] digit;
  logic unlock, fail, changed, open, locked, changing;
  logic [MAX_LEN-1:0] len_leds;

  passcode_checker #(
    .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .DIGIT_W(DIGIT_W),
    .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .on(on), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .change_req(change_req), .clear_code(clear_code),
    .unlock(unlock), .fail(fail), .changed(changed), .open(open),
    .locked(locked), .changing(changing), .len_leds(len_leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_print  = 0;

  typedef struct {
    logic o, dv, en, cr, cc;
    logic [3:0] d;
    int   n;
    logic unl, fl, chd, opn, chg;
  } vec_t;
  vec_t vq[$];

  function automatic logic [MAX_LEN-1:0] therm(input int n);
    logic [MAX_LEN-1:0] t;
    for (int i = 0; i < MAX_LEN; i++) t[i] = (n > i);
    return t;
  endfunction

  function automatic logic [MAX_LEN+5:0] pack(input int n, input logic unl, fl, chd, opn, lck, chg);
    return {therm(n), unl, fl, chd, opn, lck, chg};
  endfunction

  task automatic check(input string name, input logic [MAX_LEN+5:0] exp);
    logic [MAX_LEN+5:0] act;
    act = {len_leds, unlock, fail, changed, open, locked, changing};
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      if (n_print < 30)
        $display("FAIL %s: got leds/unl/fail/chd/open/lck/chg=%b required %b", name, act, exp);
      n_print++;
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic drive(input logic o, dv, input logic [3:0] d, input logic en, cr, cc);
    on = o; digit_valid = dv; digit = d; enter = en; change_req = cr; clear_code = cc;
    @(posedge clk);
    #1;
    digit_valid = 1'b0; enter = 1'b0; change_req = 1'b0; clear_code = 1'b0;
  endtask

  task automatic do_reset();
    on = 1'b1; digit_valid = 1'b0; digit = '0; enter = 1'b0; change_req = 1'b0; clear_code = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // digit i of a code word is digs[31-4*i -: 4], so 32'h1234_0000 means 1,2,3,4
  task automatic feed(input int len, input logic [31:0] digs);
    for (int i = 0; i < len; i++) drive(1'b1, 1'b1, digs[31-4*i -: 4], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input logic o, dv, input logic [3:0] d, input logic en, cr, cc,
                     input int n, input logic unl, fl, chd, opn, chg);
    vec_t v;
    v.o = o; v.dv = dv; v.d = d; v.en = en; v.cr = cr; v.cc = cc;
    v.n = n; v.unl = unl; v.fl = fl; v.chd = chd; v.opn = opn; v.chg = chg;
    vq.push_back(v);
  endtask

  task automatic add_code(input int len, input logic [31:0] digs, input logic opn, chg);
    for (int i = 0; i < len; i++)
      add(1, 1, digs[31-4*i -: 4], 0, 0, 0, (i + 1 > MAX_LEN) ? MAX_LEN : i + 1, 0, 0, 0, opn, chg);
  endtask

  // Reference model: entry/code/temp as digit queues; change mode is
  // "waiting for new code" while temp is empty and "confirming" once it holds one.
  int m_entry[$], m_code[$], m_temp[$];
  bit m_open, m_chg;
  int m_fails, m_lock_left;
  bit e_unl, e_fl, e_chd;

  function automatic bit same_q(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_entry.delete(); m_temp.delete(); m_code.delete();
    for (int i = 0; i < MAX_LEN; i++) m_code.push_back(0);
    m_open = 0; m_chg = 0; m_fails = 0; m_lock_left = 0;
  endtask

  task automatic model_step(input bit o, dv, input int d, input bit en, cr, cc);
    e_unl = 0; e_fl = 0; e_chd = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (!o) begin
      m_entry.delete(); m_open = 0; m_chg = 0; m_temp.delete();
    end else if (cc) begin
      m_code.delete();
      for (int i = 0; i < MAX_LEN; i++) m_code.push_back(0);
      m_entry.delete(); m_chg = 0; m_temp.delete();
    end else if (en) begin
      if (!m_chg) begin
        if (same_q(m_entry, m_code)) begin
          e_unl = 1; m_open = 1; m_fails = 0;
        end else begin
          e_fl = 1; m_fails++;
          if (m_fails == MAX_FAIL) m_lock_left = LOCK_CYCLES;
        end
      end else if (m_temp.size() == 0) begin
        if (m_entry.size() >= MIN_LEN) m_temp = m_entry;
        else e_fl = 1;
      end else begin
        if (same_q(m_entry, m_temp)) begin
          m_code = m_temp; e_chd = 1; m_chg = 0;
        end else e_fl = 1;
        m_temp.delete();
      end
      m_entry.delete();
    end else if (cr) begin
      if (!m_chg && m_open) begin m_chg = 1; m_entry.delete(); end
    end else if (dv) begin
      if (m_entry.size() < MAX_LEN) m_entry.push_back(d);
    end
  endtask

  initial begin
    int good;
    reset = 1'b1;
    do_reset();
    check("reset_state", pack(0, 0, 0, 0, 0, 0, 0));

    // ---- table-driven vectors (default code 000000) ----
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(6, 32'h0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_code(7, 32'h3333_3330, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(6, 32'h0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    add(1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    add_code(3, 32'h1230_0000, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
    add_code(4, 32'h5555_0000, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add_code(4, 32'h5556_0000, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
    add_code(4, 32'h1234_0000, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add_code(4, 32'h1234_0000, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_code(4, 32'h1234_0000, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    add_code(6, 32'h0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    add_code(2, 32'h1200_0000, 1, 0);
    add(1, 1, 7, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add_code(6, 32'h0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    add_code(2, 32'h4400_0000, 1, 1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add_code(6, 32'h0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    foreach (vq[i]) begin
      drive(vq[i].o, vq[i].dv, vq[i].d, vq[i].en, vq[i].cr, vq[i].cc);
      check($sformatf("vec%0d", i), pack(vq[i].n, vq[i].unl, vq[i].fl, vq[i].chd, vq[i].opn, 1'b0, vq[i].chg));
    end

    // ---- lockout after three wrong entries ----
    do_reset();
    for (int k = 0; k < MAX_FAIL; k++) begin
      feed(4, 32'h1234_0000);
      drive(1, 0, 0, 1, 0, 0);
      check($sformatf("lock_fail%0d", k), pack(0, 0, 1, 0, 0, k == MAX_FAIL - 1, 0));
    end
    good = 0;
    for (int c = 2; c <= LOCK_CYCLES; c++) begin
      drive((c % 17) != 0, 1'b1, 4'(c), (c % 5) == 0, (c % 7) == 0, (c % 11) == 0);
      if ({len_leds, unlock, fail, changed, open, locked, changing} === pack(0, 0, 0, 0, 0, 1, 0)) good++;
    end
    check_val("lockout_hold_cycles", good, LOCK_CYCLES - 1);
    drive(1, 0, 0, 0, 0, 0);
    check("lockout_release", pack(0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < MAX_FAIL - 1; k++) begin
      feed(4, 32'h1234_0000);
      drive(1, 0, 0, 1, 0, 0);
    end
    check("fail_cnt_cleared", pack(0, 0, 1, 0, 0, 0, 0));
    feed(6, 32'h0);
    drive(1, 0, 0, 1, 0, 0);
    check("post_lock_unlock", pack(0, 1, 0, 0, 1, 0, 0));

    // ---- reset during lockout after a code change ----
    do_reset();
    feed(6, 32'h0);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    feed(4, 32'h1234_0000);
    drive(1, 0, 0, 1, 0, 0);
    feed(4, 32'h1234_0000);
    drive(1, 0, 0, 1, 0, 0);
    check("chg_commit", pack(0, 0, 0, 1, 1, 0, 0));
    for (int k = 0; k < MAX_FAIL; k++) begin
      feed(6, 32'h0);
      drive(1, 0, 0, 1, 0, 0);
    end
    check("locked_after_change", pack(0, 0, 1, 0, 1, 1, 0));
    for (int k = 0; k < 10; k++) drive(1, 0, 0, 0, 0, 0);
    #3 reset = 1'b1;
    #1 check("async_reset_mid_lock", pack(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    feed(6, 32'h0);
    drive(1, 0, 0, 1, 0, 0);
    check("reset_restores_code", pack(0, 1, 0, 0, 1, 0, 0));

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 8000; c++) begin
      bit o, dv, en, cr, cc;
      int d;
      o  = ($urandom_range(0, 39) != 0);
      dv = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(0, 15);
      en = ($urandom_range(0, 7) == 0);
      cr = ($urandom_range(0, 19) == 0);
      cc = ($urandom_range(0, 99) == 0);
      model_step(o, dv, d, en, cr, cc);
      drive(o, dv, 4'(d), en, cr, cc);
      check($sformatf("rand_c%0d", c),
            pack(m_entry.size(), e_unl, e_fl, e_chd, m_open, m_lock_left > 0, m_chg));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
